// File: rtl/pwm_decoder.sv
// Measures high time and rising-to-rising period of an asynchronous PWM input,
// strobing o_valid once per completed cycle and flagging counter saturation.
module pwm_decoder #(
  parameter int unsigned CTRBITS = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_pwm,
  output logic [CTRBITS-1:0] o_high,
  output logic [CTRBITS-1:0] o_period,
  output logic               o_valid,
  output logic               o_timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_HIGH,
    S_LOW,
    S_TIMEOUT
  } state_t;

  localparam logic [CTRBITS-1:0] CNT_MAX = '1;
  localparam logic [CTRBITS-1:0] CNT_ONE = CTRBITS'(1);

  state_t             state_q, state_d;
  logic               sync1_q, sync2_q, hist_q;
  logic [1:0]         fill_q;
  logic [CTRBITS-1:0] hcnt_q, hcnt_d;
  logic [CTRBITS-1:0] pcnt_q, pcnt_d;
  logic [CTRBITS-1:0] high_q, high_d;
  logic [CTRBITS-1:0] period_q, period_d;
  logic               valid_q, valid_d;
  logic               tmo_q, tmo_d;
  logic               rise, fall;
  logic [CTRBITS-1:0] pcnt_sat_inc;

  assign rise         = sync2_q & ~hist_q;
  assign fall         = ~sync2_q & hist_q;
  assign pcnt_sat_inc = (pcnt_q == CNT_MAX) ? pcnt_q : pcnt_q + CNT_ONE;

  // fill_q marks when sync2_q holds a real sample rather than its reset zero,
  // so a line already high at reset release is never mistaken for a low.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
      fill_q  <= '0;
    end else begin
      sync1_q <= i_pwm;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
      fill_q  <= {fill_q[0], 1'b1};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      hcnt_q   <= '0;
      pcnt_q   <= '0;
      high_q   <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      hcnt_q   <= hcnt_d;
      pcnt_q   <= pcnt_d;
      high_q   <= high_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      tmo_q    <= tmo_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    hcnt_d   = hcnt_q;
    pcnt_d   = pcnt_q;
    high_d   = high_q;
    period_d = period_q;
    valid_d  = 1'b0;
    tmo_d    = tmo_q;
    case (state_q)
      S_IDLE: begin
        if (fill_q[1] && !sync2_q) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (rise) begin
          hcnt_d  = CNT_ONE;
          pcnt_d  = CNT_ONE;
          tmo_d   = 1'b0;
          state_d = S_HIGH;
        end
      end
      S_HIGH: begin
        if (fall) begin
          pcnt_d  = pcnt_sat_inc;
          state_d = S_LOW;
        end else if (pcnt_q == CNT_MAX) begin
          tmo_d   = 1'b1;
          state_d = S_TIMEOUT;
        end else begin
          hcnt_d = hcnt_q + CNT_ONE;
          pcnt_d = pcnt_q + CNT_ONE;
        end
      end
      S_LOW: begin
        if (rise) begin
          high_d   = hcnt_q;
          period_d = pcnt_q;
          valid_d  = 1'b1;
          hcnt_d   = CNT_ONE;
          pcnt_d   = CNT_ONE;
          state_d  = S_HIGH;
        end else if (pcnt_q == CNT_MAX) begin
          tmo_d   = 1'b1;
          state_d = S_TIMEOUT;
        end else begin
          pcnt_d = pcnt_q + CNT_ONE;
        end
      end
      S_TIMEOUT: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  assign o_high    = high_q;
  assign o_period  = period_q;
  assign o_valid   = valid_q;
  assign o_timeout = tmo_q;

endmodule

// File: tb/tb_pwm_decoder.sv
// Drives one PWM waveform into a 16-bit and an 8-bit decoder and compares both
// against a waveform-level reference model every clock cycle.
module tb_pwm_decoder;

  logic        clk;
  logic        rst_n;
  logic        pwm;
  logic [15:0] high16, period16;
  logic        valid16, tmo16;
  logic [7:0]  high8, period8;
  logic        valid8, tmo8;

  pwm_decoder #(.CTRBITS(16)) dut16 (
    .i_clk(clk), .i_rst_n(rst_n), .i_pwm(pwm),
    .o_high(high16), .o_period(period16), .o_valid(valid16), .o_timeout(tmo16)
  );

  pwm_decoder #(.CTRBITS(8)) dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_pwm(pwm),
    .o_high(high8), .o_period(period8), .o_valid(valid8), .o_timeout(tmo8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int DEPTH = 16384;

  int total  = 0;
  int passed = 0;
  int cyc    = 0;

  // Expected outputs, indexed by the clock cycle in which the raw level was
  // sampled; the decoder shows them two cycles later.
  int ev [2][DEPTH];
  int eh [2][DEPTH];
  int ep [2][DEPTH];
  int et [2][DEPTH];

  // Waveform-level model: time since the last accepted rise, high time so far.
  int maxv [2] = '{65535, 255};
  int m_lvp [2], m_meas [2], m_armed [2], m_skip [2];
  int m_h [2], m_cnt [2], m_oh [2], m_op [2], m_ot [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s at cycle %0d: observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_lvp[m] = 0; m_meas[m] = 0; m_armed[m] = 0; m_skip[m] = 0;
      m_h[m] = 0; m_cnt[m] = 0; m_oh[m] = 0; m_op[m] = 0; m_ot[m] = 0;
    end
  endtask

  task automatic record(input int m, input int v);
    ev[m][cyc % DEPTH] = v;
    eh[m][cyc % DEPTH] = m_oh[m];
    ep[m][cyc % DEPTH] = m_op[m];
    et[m][cyc % DEPTH] = m_ot[m];
  endtask

  task automatic model_step(input int m, input int lv);
    int r, f, v;
    r = (lv == 1 && m_lvp[m] == 0) ? 1 : 0;
    f = (lv == 0 && m_lvp[m] == 1) ? 1 : 0;
    v = 0;
    if (m_meas[m] != 0) begin
      if (r != 0) begin
        v = 1;
        m_oh[m] = m_h[m];
        m_op[m] = m_cnt[m];
        m_h[m] = 1;
        m_cnt[m] = 1;
      end else if (f == 0 && m_cnt[m] == maxv[m]) begin
        m_meas[m] = 0; m_armed[m] = 0; m_skip[m] = 1; m_ot[m] = 1;
      end else begin
        if (lv != 0) m_h[m]++;
        if (m_cnt[m] < maxv[m]) m_cnt[m]++;
      end
    end else if (m_skip[m] != 0) begin
      m_skip[m] = 0;
    end else if (m_armed[m] != 0 && r != 0) begin
      m_meas[m] = 1; m_h[m] = 1; m_cnt[m] = 1; m_ot[m] = 0;
    end else if (lv == 0) begin
      m_armed[m] = 1;
    end
    m_lvp[m] = lv;
    record(m, v);
  endtask

  task automatic check_outputs();
    int i;
    if (cyc >= 2) begin
      i = (cyc - 2) % DEPTH;
      chk("d16.valid",  32'(valid16),  ev[0][i]);
      chk("d16.high",   32'(high16),   eh[0][i]);
      chk("d16.period", 32'(period16), ep[0][i]);
      chk("d16.tmo",    32'(tmo16),    et[0][i]);
      chk("d8.valid",   32'(valid8),   ev[1][i]);
      chk("d8.high",    32'(high8),    eh[1][i]);
      chk("d8.period",  32'(period8),  ep[1][i]);
      chk("d8.tmo",     32'(tmo8),     et[1][i]);
    end
  endtask

  task automatic tick(input int lv);
    @(negedge clk);
    check_outputs();
    pwm = lv[0];
    @(posedge clk);
    cyc++;
    model_step(0, lv);
    model_step(1, lv);
  endtask

  task automatic seg(input int lv, input int n);
    for (int k = 0; k < n; k++) tick(lv);
  endtask

  task automatic cycles(input int h, input int l, input int reps);
    for (int k = 0; k < reps; k++) begin
      seg(1, h);
      seg(0, l);
    end
  endtask

  task automatic reset_dut(input int lv);
    @(negedge clk);
    check_outputs();
    rst_n = 1'b0;
    pwm   = lv[0];
    #1;
    chk("rst.d16.valid",  32'(valid16),  0);
    chk("rst.d16.high",   32'(high16),   0);
    chk("rst.d16.period", 32'(period16), 0);
    chk("rst.d16.tmo",    32'(tmo16),    0);
    chk("rst.d8.valid",   32'(valid8),   0);
    chk("rst.d8.high",    32'(high8),    0);
    chk("rst.d8.period",  32'(period8),  0);
    chk("rst.d8.tmo",     32'(tmo8),     0);
    model_reset();
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      cyc++;
      record(0, 0);
      record(1, 0);
      @(negedge clk);
    end
    rst_n = 1'b1;
    @(posedge clk);
    cyc++;
    model_step(0, lv);
    model_step(1, lv);
  endtask

  initial begin
    rst_n = 1'b0;
    pwm   = 1'b0;
    model_reset();
    reset_dut(0);

    // steady 30/70
    seg(0, 10);
    cycles(30, 70, 5);
    // square wave of single-cycle phases
    cycles(1, 1, 20);
    // duty change 10/90 -> 60/40
    cycles(10, 90, 3);
    cycles(60, 40, 3);
    // random H/L within the 8-bit range
    for (int k = 0; k < 20; k++) begin
      cycles(int'($urandom_range(1, 40)), int'($urandom_range(1, 40)), 1);
    end
    seg(1, 5);
    seg(0, 5);

    // reset in the middle of a low phase
    cycles(20, 20, 2);
    seg(1, 20);
    seg(0, 10);
    reset_dut(0);
    seg(0, 10);
    cycles(20, 20, 2);
    seg(1, 20);
    seg(0, 5);

    // line already high across reset release
    reset_dut(1);
    seg(1, 15);
    seg(0, 10);
    cycles(25, 25, 2);
    seg(1, 25);
    seg(0, 5);

    // 8-bit counter saturation and recovery
    cycles(40, 40, 1);
    seg(1, 300);
    seg(0, 10);
    cycles(20, 20, 2);
    seg(1, 20);
    seg(0, 8);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
